// File: rtl/q3_alu_arbiter_if.sv
// Purpose: command/response bundle between two requesters, the arbiter and the
//          result consumer.
// Signals: req0_*/req1_* valid/ready command channels carrying signed A/B and
//          a 2-bit select; rsp_* valid/ready response channel carrying the
//          signed result, the requester id and the select performed.
// Modports: slave = arbiter side, master = requester/consumer side.
interface q3_alu_arbiter_if;
  localparam int unsigned DW = 6;
  localparam int unsigned SW = 2;

  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [SW-1:0] req0_sel;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [SW-1:0] req1_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;
  logic [SW-1:0] rsp_sel;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_sel,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_sel,
    output rsp_ready
  );
endinterface

// File: rtl/q3_alu_arbiter.sv
// Purpose: two requesters share one 6-bit signed four-operation ALU through a
//          round-robin arbiter; results go into a single-entry response buffer.
// Ports:   clk, rst_n (async active-low); bus (slave modport: two command
//          channels, one response channel); busy mirrors rsp_valid; done_cnt
//          counts response handshakes modulo 2^CNT_W.
module q3_alu_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  q3_alu_arbiter_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int unsigned DW = 6;
  localparam int unsigned SW = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic             id_q, id_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept_c;
  logic             grant0_c;
  logic             grant1_c;
  logic [DW-1:0]    op_a_c;
  logic [DW-1:0]    op_b_c;
  logic [SW-1:0]    op_sel_c;
  logic [DW-1:0]    alu_res_c;
  logic signed [DW-1:0] a_s_c;
  logic signed [DW-1:0] b_s_c;
  logic signed [DW-1:0] t_s_c;

  // Round-robin grant; prio_q names the port that wins a tie.
  always_comb begin
    can_accept_c = (state_q == ST_EMPTY) || bus.rsp_ready;
    grant0_c     = can_accept_c && bus.req0_valid && (!bus.req1_valid || !prio_q);
    grant1_c     = can_accept_c && bus.req1_valid && (!bus.req0_valid ||  prio_q);
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;

  // Operand mux and ALU; every result wraps to 6-bit two's complement.
  always_comb begin
    op_a_c    = grant1_c ? bus.req1_a   : bus.req0_a;
    op_b_c    = grant1_c ? bus.req1_b   : bus.req0_b;
    op_sel_c  = grant1_c ? bus.req1_sel : bus.req0_sel;
    a_s_c     = op_a_c;
    b_s_c     = op_b_c;
    t_s_c     = '0;
    alu_res_c = '0;
    case (op_sel_c)
      2'b00: alu_res_c = (a_s_c <<< 2) + (b_s_c >>> 1);
      2'b01: alu_res_c = a_s_c + b_s_c + (b_s_c <<< 1);
      2'b10: alu_res_c = a_s_c - b_s_c;
      default: begin
        // -(-32) wraps back to -32 in six bits, which is the intended result.
        t_s_c     = (a_s_c <<< 1) - b_s_c;
        alu_res_c = t_s_c[DW-1] ? -t_s_c : t_s_c;
      end
    endcase
  end

  // Buffer FSM, priority pointer and completion counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;

    if ((state_q == ST_FULL) && bus.rsp_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_EMPTY: if (grant0_c || grant1_c) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !(grant0_c || grant1_c)) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (grant0_c || grant1_c) begin
      data_d = alu_res_c;
      id_d   = grant1_c;
      sel_d  = op_sel_c;
      prio_d = grant0_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      sel_q   <= '0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sel   = sel_q;
  assign busy          = (state_q == ST_FULL);
  assign done_cnt      = cnt_q;
endmodule

// File: tb/tb_q3_alu_arbiter.sv
// Purpose: self-checking bench for q3_alu_arbiter. A main instance (CNT_W=8)
//          and a narrow-counter instance (CNT_W=2) see identical stimulus.
module tb_q3_alu_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  q3_alu_arbiter_if bus ();
  q3_alu_arbiter_if bus2 ();

  assign bus2.req0_valid = bus.req0_valid;
  assign bus2.req0_a     = bus.req0_a;
  assign bus2.req0_b     = bus.req0_b;
  assign bus2.req0_sel   = bus.req0_sel;
  assign bus2.req1_valid = bus.req1_valid;
  assign bus2.req1_a     = bus.req1_a;
  assign bus2.req1_b     = bus.req1_b;
  assign bus2.req1_sel   = bus.req1_sel;
  assign bus2.rsp_ready  = bus.rsp_ready;

  logic       busy, busy2;
  logic [7:0] done_cnt;
  logic [1:0] done_cnt2;

  q3_alu_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done_cnt(done_cnt)
  );
  q3_alu_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .done_cnt(done_cnt2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int wrap6(input int x);
    int m;
    m = x % 64;
    if (m < 0) m += 64;
    if (m >= 32) m -= 64;
    return m;
  endfunction

  function automatic int floor_half(input int b);
    if (b < 0 && (b % 2) != 0) return b / 2 - 1;
    return b / 2;
  endfunction

  function automatic int alu_model(input int sel, input int a, input int b);
    int t;
    case (sel)
      0: return wrap6(4 * a + floor_half(b));
      1: return wrap6(a + 3 * b);
      2: return wrap6(a - b);
      default: begin
        t = wrap6(2 * a - b);
        return (t < 0) ? wrap6(-t) : t;
      end
    endcase
  endfunction

  int m_valid = 0;
  int m_data  = 0;
  int m_id    = 0;
  int m_sel   = 0;
  int m_fav   = 0;
  int m_cnt   = 0;
  int m_g;

  function automatic int model_grant();
    if (m_valid != 0 && !bus.rsp_ready) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_fav;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  always_comb m_g = model_grant();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_data <= 0; m_id <= 0; m_sel <= 0; m_fav <= 0; m_cnt <= 0;
    end else begin
      if (m_valid != 0 && bus.rsp_ready) m_cnt <= m_cnt + 1;
      if (m_g == 0) begin
        m_valid <= 1;
        m_data  <= alu_model(int'(bus.req0_sel), int'($signed(bus.req0_a)), int'($signed(bus.req0_b)));
        m_id    <= 0;
        m_sel   <= int'(bus.req0_sel);
        m_fav   <= 1;
      end else if (m_g == 1) begin
        m_valid <= 1;
        m_data  <= alu_model(int'(bus.req1_sel), int'($signed(bus.req1_a)), int'($signed(bus.req1_b)));
        m_id    <= 1;
        m_sel   <= int'(bus.req1_sel);
        m_fav   <= 0;
      end else if (m_valid != 0 && bus.rsp_ready) begin
        m_valid <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rsp_valid", bus.rsp_valid, m_valid);
      check("busy", busy, m_valid);
      if (m_valid != 0) begin
        check("rsp_data", $signed(bus.rsp_data), m_data);
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_sel", bus.rsp_sel, m_sel);
      end
      check("req0_ready", bus.req0_ready, m_g == 0);
      check("req1_ready", bus.req1_ready, m_g == 1);
      check("done_cnt", done_cnt, m_cnt % 256);
      check("done_cnt_w2", done_cnt2, m_cnt % 4);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic op0(input int sel, input int a, input int b, input int exp, input string name);
    bus.req0_a     = 6'(a);
    bus.req0_b     = 6'(b);
    bus.req0_sel   = 2'(sel);
    bus.req0_valid = 1'b1;
    #1 check({name, "_ready"}, bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    check({name, "_valid"}, bus.rsp_valid, 1);
    check({name, "_data"}, $signed(bus.rsp_data), exp);
    check({name, "_id"}, bus.rsp_id, 0);
    check({name, "_sel"}, bus.rsp_sel, sel);
  endtask

  int seq [5] = '{1, 2, 3, 0, 1};
  int saved_cnt;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
    bus.rsp_ready  = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_sel", bus.rsp_sel, 0);
    check("rst_cnt", done_cnt, 0);
    #5 rst_n = 1'b1;
    tick();

    // Single operations on port 0
    bus.rsp_ready = 1'b1;
    op0(0,   3, -3,  10, "sel00");
    op0(1,  10, 10, -24, "sel01");
    op0(2, -32,  1,  31, "sel10");
    op0(3,  -5,  6,  16, "sel11");
    op0(3, -16,  0, -32, "sel11_m32");
    op0(3,  20,  8, -32, "sel11_wrap");
    tick();

    // Contention from reset: grants alternate 0,1,0,1...
    do_reset();
    bus.req0_a = 6'(1); bus.req0_b = 6'(1); bus.req0_sel = 2'(2); bus.req0_valid = 1'b1;
    bus.req1_a = 6'(5); bus.req1_b = 6'(2); bus.req1_sel = 2'(1); bus.req1_valid = 1'b1;
    #1;
    check("cont_r0", bus.req0_ready, 1);
    check("cont_r1", bus.req1_ready, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("cont_valid", bus.rsp_valid, 1);
      check("cont_id", bus.rsp_id, i % 2);
      check("cont_data", $signed(bus.rsp_data), (i % 2) != 0 ? 11 : 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    // Backpressure: hold for 5 cycles, then drain and reload together
    bus.rsp_ready = 1'b0;
    bus.req0_a = 6'(3); bus.req0_b = 6'(-3); bus.req0_sel = 2'(0); bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_a = 6'(-5); bus.req1_b = 6'(6); bus.req1_sel = 2'(3); bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_r0", bus.req0_ready, 0);
      check("bp_r1", bus.req1_ready, 0);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_data", $signed(bus.rsp_data), 10);
      check("bp_id", bus.rsp_id, 0);
      tick();
    end
    saved_cnt = m_cnt;
    bus.rsp_ready = 1'b1;
    #1 check("bp_release_r1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    check("bp_new_valid", bus.rsp_valid, 1);
    check("bp_new_data", $signed(bus.rsp_data), 16);
    check("bp_new_id", bus.rsp_id, 1);
    check("bp_cnt_inc", done_cnt, (saved_cnt + 1) % 256);
    tick();

    // Counter wrap on the CNT_W=2 instance
    do_reset();
    bus.req0_a = 6'(1); bus.req0_b = 6'(0); bus.req0_sel = 2'(2); bus.req0_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 2) begin
        check("wrap_cnt2", done_cnt2, seq[k-2]);
        check("wrap_cnt8", done_cnt, k - 1);
      end
    end

    // Asynchronous reset while FULL, then tie goes to port 0
    bus.req1_a = 6'(2); bus.req1_b = 6'(1); bus.req1_sel = 2'(2); bus.req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", done_cnt, 0);
    check("mid_rst_cnt2", done_cnt2, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_r0", bus.req0_ready, 1);
    check("post_rst_r1", bus.req1_ready, 0);
    tick();
    check("post_rst_id0", bus.rsp_id, 0);
    check("post_rst_data0", $signed(bus.rsp_data), 1);
    tick();
    check("post_rst_id1", bus.rsp_id, 1);
    check("post_rst_data1", $signed(bus.rsp_data), 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
